// File: rtl/regbank_rr_ctrl.sv
// regbank_rr_ctrl: round-robin arbitrated write port in front of a small
// resettable register bank. A clear sequencer zeroes the bank one entry
// per cycle and blocks all writes while it runs. Reads are combinational.
module regbank_rr_ctrl #(
    parameter  int NREQ  = 4,
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*AW-1:0]    wr_addr,
    input  logic [NREQ*WIDTH-1:0] wr_data,
    output logic [NREQ-1:0]       gnt,
    input  logic                  clr_all,
    output logic                  clr_busy,
    input  logic [AW-1:0]         rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [AW-1:0]    clr_idx;
    logic             clr_busy_q;
    logic [WIDTH-1:0] bank [DEPTH];

    // Arbitration results
    int               scan_idx;
    logic             found;
    logic [PW-1:0]    gnt_idx;
    logic             grant_ok;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;

    // Round-robin search starting at ptr, then mux the winner's address/data
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        scan_idx = 0;
        found    = 1'b0;
        gnt_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!found && req[PW'(scan_idx)]) begin
                found   = 1'b1;
                gnt_idx = PW'(scan_idx);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                sel_addr = wr_addr[i*AW +: AW];
                sel_data = wr_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A grant exists only in IDLE, out of reset, with no clear request pending
    assign grant_ok = (state == IDLE) && !clr_all && !reset && found;
    assign gnt      = grant_ok ? (NREQ'(1) << gnt_idx) : '0;
    assign clr_busy = clr_busy_q;
    assign rd_data  = bank[rd_addr];

    // Sequencer, round-robin pointer and bank storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            clr_idx    <= '0;
            clr_busy_q <= 1'b0;
            // NOTE: the bank is architecturally resettable, so every entry is cleared here
            // (this costs a reset on each flop; a plain RAM would not be reset).
            for (int d = 0; d < DEPTH; d++) begin
                bank[d] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so all
            // registers update together from the pre-edge values.
            case (state)
                IDLE: begin
                    if (clr_all) begin
                        state      <= CLEAR;
                        clr_idx    <= '0;
                        clr_busy_q <= 1'b1;
                    end else if (grant_ok) begin
                        bank[sel_addr] <= sel_data;
                        ptr            <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    end
                end
                CLEAR: begin
                    bank[clr_idx] <= '0;
                    if (clr_idx == AW'(DEPTH - 1)) begin
                        state      <= IDLE;
                        clr_idx    <= '0;
                        clr_busy_q <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    clr_idx    <= '0;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
